band_update_ctrl: RTL and testbench

Write-side controller for the LED strip driver's 64x24 colour memory. It holds a shadow frame that the host writes at any time, tracks which entries are dirty, and flushes them into the driver's write port only inside the driver's write window (driver wen_o high during the latch gap). It also reports flush completion and counts missed windows. An optional rotation mode steps the displayed pattern by one LED per frame.

---
 rtl/band_pkg.sv | 19 +
 rtl/band_dirty_tracker.sv | 37 +++
 rtl/band_update_ctrl.sv | 139 +++++++++++++
 tb/tb_band_update_ctrl.sv | 268 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/band_pkg.sv
// Shared types and sizes for the LED strip colour path (band_update_ctrl, band_drive).
// Rotation is a build option of band_update_ctrl (macro ROTATE_EN); nothing here depends on it.
package band_pkg;

    localparam int ADDR_W  = 6;
    localparam int COLOR_W = 24;
    localparam int N_LEDS  = 2 ** ADDR_W;

    typedef logic [COLOR_W-1:0] color_t;
    typedef logic [ADDR_W-1:0]  addr_t;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SCAN  = 2'd1,
        WRITE = 2'd2,
        DONE  = 2'd3
    } state_t;

endpackage

// File: rtl/band_dirty_tracker.sv
// Per-LED dirty bits for the shadow frame, plus a registered any-dirty flag.
// A host set always overrides a same-cycle commit clear of the same entry.
module band_dirty_tracker
    import band_pkg::*;
(
    input  logic              clk,
    input  logic              reset,
    input  logic              set_en,
    input  addr_t             set_idx,
    input  logic              clr_en,
    input  addr_t             clr_idx,
    input  logic              set_all,
    output logic [N_LEDS-1:0] dirty,
    output logic              any_dirty
);

    logic [N_LEDS-1:0] dirty_nxt;

    // Order matters: clear first, then sets, so the host wins any collision.
    always_comb begin
        dirty_nxt = dirty;
        if (clr_en) dirty_nxt[clr_idx] = 1'b0;
        if (set_all) dirty_nxt = '1;
        if (set_en) dirty_nxt[set_idx] = 1'b1;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            dirty     <= '0;
            any_dirty <= 1'b0;
        end else begin
            dirty     <= dirty_nxt;
            any_dirty <= |dirty_nxt;
        end
    end

endmodule

// File: rtl/band_update_ctrl.sv
// Flushes host-written shadow colours into the LED driver's write port while its window is open.
// Build option ROTATE_EN: each frame shifts driver addresses by one LED (offset), shadow untouched.
//
// state | meaning
// IDLE  | window closed, driver port quiet
// SCAN  | walking ptr round-robin looking for a dirty entry
// WRITE | drv_wen held; the next edge with drv_win high is the accept
// DONE  | every dirty entry committed in this window
module band_update_ctrl
    import band_pkg::*;
(
    input  logic               clk,
    input  logic               reset,
    input  logic               host_wr,
    input  logic [ADDR_W-1:0]  host_addr,
    input  logic [COLOR_W-1:0] host_data,
    input  logic               drv_win,
    output logic [ADDR_W-1:0]  drv_addr,
    output logic [COLOR_W-1:0] drv_data,
    output logic               drv_wen,
    input  logic               rot_en,
    output logic               pending,
    output logic               flush_done,
    output logic [7:0]         miss_cnt
);

    state_t            state;
    addr_t             ptr;
    addr_t             tgt_addr;
    color_t            shadow [N_LEDS];
    logic [N_LEDS-1:0] dirty;
    logic              commit;
    logic              set_all;
    logic              window_lost;

`ifdef ROTATE_EN
    addr_t offset;

    assign set_all  = (state == IDLE) && drv_win && rot_en;
    assign tgt_addr = ptr + offset;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            offset <= '0;
        end else if (set_all) begin
            offset <= offset + 1'b1;
        end
    end
`else
    logic unused_rot_en;

    assign unused_rot_en = rot_en;
    assign set_all       = 1'b0;
    assign tgt_addr      = ptr;
`endif

    assign commit      = (state == WRITE) && drv_win;
    assign window_lost = !drv_win && (|dirty) && ((state == SCAN) || (state == WRITE));

    band_dirty_tracker u_dirty (
        .clk       (clk),
        .reset     (reset),
        .set_en    (host_wr),
        .set_idx   (host_addr),
        .clr_en    (commit),
        .clr_idx   (ptr),
        .set_all   (set_all),
        .dirty     (dirty),
        .any_dirty (pending)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < N_LEDS; i++) shadow[i] <= '0;
        end else if (host_wr) begin
            shadow[host_addr] <= host_data;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            miss_cnt <= '0;
        end else if (window_lost && (miss_cnt != 8'hFF)) begin
            miss_cnt <= miss_cnt + 8'd1;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state      <= IDLE;
            ptr        <= '0;
            drv_addr   <= '0;
            drv_data   <= '0;
            drv_wen    <= 1'b0;
            flush_done <= 1'b0;
        end else begin
            flush_done <= 1'b0;
            case (state)
                IDLE: begin
                    drv_wen <= 1'b0;
                    if (drv_win) state <= SCAN;
                end
                SCAN: begin
                    if (!drv_win) begin
                        state <= IDLE;
                    end else if (dirty[ptr]) begin
                        drv_addr <= tgt_addr;
                        drv_data <= shadow[ptr];
                        drv_wen  <= 1'b1;
                        state    <= WRITE;
                    end else begin
                        ptr <= ptr + 1'b1;
                        // Only a full clean lap ending at the last index declares the frame done.
                        if ((&ptr) && !(|dirty)) begin
                            state      <= DONE;
                            flush_done <= 1'b1;
                        end
                    end
                end
                WRITE: begin
                    drv_wen <= 1'b0;
                    if (drv_win) begin
                        ptr   <= ptr + 1'b1;
                        state <= SCAN;
                    end else begin
                        state <= IDLE;
                    end
                end
                DONE: begin
                    drv_wen <= 1'b0;
                    if (!drv_win) state <= IDLE;
                    else if (|dirty) state <= SCAN;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_band_update_ctrl.sv
// Bench for band_update_ctrl: directed steps plus random host traffic against a frame-level model.
module tb_band_update_ctrl;

    logic        clk = 1'b0;
    logic        reset;
    logic        host_wr;
    logic [5:0]  host_addr;
    logic [23:0] host_data;
    logic        drv_win;
    logic [5:0]  drv_addr;
    logic [23:0] drv_data;
    logic        drv_wen;
    logic        rot_en;
    logic        pending;
    logic        flush_done;
    logic [7:0]  miss_cnt;

    int n_assert = 0;
    int n_fail   = 0;

    logic [23:0] m_shadow [64];
    bit          m_dirty  [64];
    int          m_ptr, m_off, m_miss, m_flush, obs_flush;
    logic [31:0] obs_q [$];
    logic [31:0] exp_q [$];

    always #5 clk = ~clk;

    band_update_ctrl dut (
        .clk        (clk),
        .reset      (reset),
        .host_wr    (host_wr),
        .host_addr  (host_addr),
        .host_data  (host_data),
        .drv_win    (drv_win),
        .drv_addr   (drv_addr),
        .drv_data   (drv_data),
        .drv_wen    (drv_wen),
        .rot_en     (rot_en),
        .pending    (pending),
        .flush_done (flush_done),
        .miss_cnt   (miss_cnt)
    );

    // A driver write is accepted at the next rising edge when wen and win are both high.
    always @(negedge clk) begin
        if (reset && drv_wen && drv_win) obs_q.push_back({2'b00, drv_addr, drv_data});
        if (reset && flush_done) obs_flush++;
    end

    initial begin
        #500000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic bit m_any();
        for (int i = 0; i < 64; i++) if (m_dirty[i]) return 1'b1;
        return 1'b0;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 64; i++) begin
            m_shadow[i] = '0;
            m_dirty[i]  = 1'b0;
        end
        m_ptr = 0; m_off = 0; m_miss = 0; m_flush = 0; obs_flush = 0;
        obs_q.delete();
        exp_q.delete();
    endtask

    task automatic do_reset();
        reset = 1'b0; host_wr = 1'b0; host_addr = '0; host_data = '0; drv_win = 1'b0; rot_en = 1'b0;
        repeat (2) tick();
        chk("rst_wen",   32'(drv_wen), 0);
        chk("rst_addr",  32'(drv_addr), 0);
        chk("rst_data",  32'(drv_data), 0);
        chk("rst_pend",  32'(pending), 0);
        chk("rst_flush", 32'(flush_done), 0);
        chk("rst_miss",  32'(miss_cnt), 0);
        reset = 1'b1;
        tick();
        model_reset();
    endtask

    task automatic host_write(input logic [5:0] a, input logic [23:0] d);
        host_wr = 1'b1; host_addr = a; host_data = d;
        tick();
        host_wr = 1'b0;
        m_shadow[a] = d;
        m_dirty[a]  = 1'b1;
    endtask

    // Frame-level cost model: one edge to open the scan, two per committed entry, one per clean entry.
    task automatic model_window(input int len, input bit rot);
        int budget;
        bit done;
        budget = len - 1;
        done   = 1'b0;
`ifdef ROTATE_EN
        if (rot) begin
            m_off = (m_off + 1) % 64;
            for (int i = 0; i < 64; i++) m_dirty[i] = 1'b1;
        end
`endif
        while (budget > 0 && !done) begin
            if (m_dirty[m_ptr]) begin
                if (budget >= 2) begin
                    exp_q.push_back({2'b00, 6'((m_ptr + m_off) % 64), m_shadow[m_ptr]});
                    m_dirty[m_ptr] = 1'b0;
                    m_ptr  = (m_ptr + 1) % 64;
                    budget -= 2;
                end else begin
                    budget = 0;
                end
            end else begin
                if (m_ptr == 63 && !m_any()) begin
                    done = 1'b1;
                    m_flush++;
                end
                m_ptr = (m_ptr + 1) % 64;
                budget--;
            end
        end
        if (!done && m_any() && m_miss < 255) m_miss++;
    endtask

    task automatic run_window(input int len, input bit rot);
        obs_q.delete(); exp_q.delete(); obs_flush = 0; m_flush = 0;
        rot_en = rot; drv_win = 1'b1;
        repeat (len) tick();
        drv_win = 1'b0; rot_en = 1'b0;
        repeat (3) tick();
        model_window(len, rot);
        chk("commit_count", obs_q.size(), exp_q.size());
        for (int i = 0; i < obs_q.size() && i < exp_q.size(); i++) chk("commit_word", obs_q[i], exp_q[i]);
        chk("flush_count", obs_flush, m_flush);
        chk("miss_cnt", 32'(miss_cnt), m_miss);
        chk("pending", 32'(pending), 32'(m_any()));
    endtask

    initial begin
        bit injected;
        bit saw_wen;

        // single entry
        do_reset();
        host_write(6'd5, 24'h123456);
        chk("pend_after_write", 32'(pending), 1);
        run_window(300, 1'b0);
        chk("t1_count", obs_q.size(), 1);
        if (obs_q.size() > 0) chk("t1_word", obs_q[0], {2'b00, 6'd5, 24'h123456});
        chk("t1_flush", obs_flush, 1);
        chk("t1_pend", 32'(pending), 0);

        // full frame
        do_reset();
        for (int i = 0; i < 64; i++) host_write(6'(i), {2'b00, 6'(i), 2'b00, 6'(i), 2'b00, 6'(i)});
        run_window(300, 1'b0);
        chk("t2_count", obs_q.size(), 64);
        chk("t2_flush", obs_flush, 1);
        chk("t2_miss", 32'(miss_cnt), 0);

        // short window then resume
        do_reset();
        for (int i = 0; i < 64; i++) host_write(6'(i), 24'($urandom));
        run_window(41, 1'b0);
        chk("t3_partial", obs_q.size(), 20);
        chk("t3_miss", 32'(miss_cnt), 1);
        run_window(300, 1'b0);
        chk("t3_rest", obs_q.size(), 44);
        if (obs_q.size() > 0) chk("t3_resume_addr", 32'(obs_q[0][29:24]), 20);

        // host rewrite on the accept edge
        do_reset();
        host_write(6'd9, 24'hff0000);
        obs_q.delete(); obs_flush = 0;
        injected = 1'b0;
        drv_win = 1'b1;
        for (int c = 0; c < 300; c++) begin
            if (!injected && drv_wen && drv_addr == 6'd9) begin
                host_wr = 1'b1; host_addr = 6'd9; host_data = 24'h00ff00;
                tick();
                host_wr = 1'b0;
                injected = 1'b1;
            end else begin
                tick();
            end
        end
        drv_win = 1'b0;
        repeat (3) tick();
        chk("t4_injected", 32'(injected), 1);
        chk("t4_count", obs_q.size(), 2);
        if (obs_q.size() > 1) begin
            chk("t4_first", obs_q[0], {2'b00, 6'd9, 24'hff0000});
            chk("t4_second", obs_q[1], {2'b00, 6'd9, 24'h00ff00});
        end
        chk("t4_flush", obs_flush, 1);
        chk("t4_pend", 32'(pending), 0);
        m_shadow[9] = 24'h00ff00; m_dirty[9] = 1'b0; m_ptr = 0;

        // reset while WRITE
        for (int i = 0; i < 4; i++) host_write(6'(i * 3), 24'($urandom));
        drv_win = 1'b1;
        saw_wen = 1'b0;
        for (int c = 0; c < 20 && !saw_wen; c++) begin
            tick();
            saw_wen = drv_wen;
        end
        chk("t5_reached_write", 32'(saw_wen), 1);
        reset = 1'b0;
        #1;
        chk("t5_wen_drop", 32'(drv_wen), 0);
        chk("t5_pend_clr", 32'(pending), 0);
        drv_win = 1'b0;
        repeat (2) tick();
        reset = 1'b1;
        model_reset();
        repeat (5) tick();
        chk("t5_idle_wen", 32'(drv_wen), 0);
        chk("t5_idle_pend", 32'(pending), 0);
        chk("t5_idle_miss", 32'(miss_cnt), 0);
        run_window(100, 1'b0);
        chk("t5_nothing_sent", obs_q.size(), 0);

        // miss counter saturation
        do_reset();
        for (int i = 0; i < 64; i++) host_write(6'(i), 24'($urandom));
        for (int w = 0; w < 260; w++) run_window(2, 1'b0);
        chk("t6_saturate", 32'(miss_cnt), 255);

        // random traffic
        do_reset();
        for (int r = 0; r < 12; r++) begin
            int nw;
            nw = $urandom_range(0, 24);
            for (int k = 0; k < nw; k++) host_write(6'($urandom_range(0, 63)), 24'($urandom));
            run_window($urandom_range(1, 200), 1'($urandom_range(0, 1)));
        end

`ifdef ROTATE_EN
        do_reset();
        host_write(6'd0, 24'habcdef);
        for (int w = 0; w < 3; w++) begin
            run_window(300, 1'b1);
            chk("rot_count", obs_q.size(), 64);
        end
        if (obs_q.size() > 0) chk("rot_idx0_word", obs_q[0], {2'b00, 6'd3, 24'habcdef});
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
